clock_time_keeper: RTL and testbench
====================================

CLOCK_TIME_KEEPER -- requirements
Module: clock_time_keeper

Interface
REQ-001 Parameter P_HOUR_MAX, default 23; the maximum hour value. 23 gives a 24 h clock. The only other legal value is 11.
REQ-002 Port i_clk, input, 1 bit: the single system clock, rising-edge active.
REQ-003 Port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 Port i_pulse, input, 1 bit: 100 ms tick from the upstream pulse generator. It is a level that may stay high for many cycles; only its rising edge counts.
REQ-005 Port i_run, input, 1 bit: run enable. When low, time is frozen.
REQ-006 Port i_set, input, 1 bit: mode button. Each rising edge advances the mode.
REQ-007 Port i_inc, input, 1 bit: increment button. Each rising edge increments the selected field.
REQ-008 Port o_hr_t, output, 2 bits: hours tens, BCD.
REQ-009 Port o_hr_u, output, 4 bits: hours units, BCD.
REQ-010 Port o_min_t, output, 3 bits: minutes tens, BCD.
REQ-011 Port o_min_u, output, 4 bits: minutes units, BCD.
REQ-012 Port o_sec_t, output, 3 bits: seconds tens, BCD.
REQ-013 Port o_sec_u, output, 4 bits: seconds units, BCD.
REQ-014 Port o_tenth, output, 4 bits: tenths of a second, 0 to 9.
REQ-015 Port o_mode, output, 2 bits: current state. 0 = RUN, 1 = SET_HR, 2 = SET_MIN.
REQ-016 Port o_sec_tick, output, 1 bit: one-cycle strobe on each tenths wrap from 9 to 0.
REQ-017 Port o_day_tick, output, 1 bit: one-cycle strobe on each P_HOUR_MAX:59:59.9 to 00:00:00.0 rollover.

Function
REQ-018 Rising-edge detection: each of i_pulse, i_set and i_inc shall have a one-register history. An edge is current = 1 with history = 0.
REQ-019 All outputs shall be registered. Latency shall be one cycle: a detected edge in cycle N is visible on the outputs in cycle N+1.
REQ-020 State machine transitions:
- RUN to SET_HR on an i_set edge.
- SET_HR to SET_MIN on an i_set edge.
- SET_MIN to RUN on an i_set edge.
- No other transitions.
REQ-021 In RUN with i_run = 1, each i_pulse edge shall increment the time:
- tenths count 0 to 9, then wrap to 0 and carry;
- seconds count 00 to 59, then wrap and carry;
- minutes count 00 to 59, then wrap and carry;
- hours count 00 to P_HOUR_MAX, then wrap to 00.
REQ-022 In RUN with i_run = 0, i_pulse edges shall be ignored and all digits shall hold.
REQ-023 In SET_HR and SET_MIN, i_pulse edges shall be ignored, and tenths and seconds shall be forced to 0.
REQ-024 In SET_HR, an i_inc edge shall increment hours modulo P_HOUR_MAX+1, with no effect on minutes.
REQ-025 In SET_MIN, an i_inc edge shall increment minutes modulo 60, with no carry into hours.
REQ-026 In RUN, i_inc edges shall be ignored.
REQ-027 i_set and i_inc edges in the same cycle: the i_inc edge shall apply to the current mode, then the mode shall advance.
REQ-028 All digit values shall stay legal BCD at all times. The maximum digit values are 2, 9, 5, 9, 5, 9, 9.
REQ-029 o_sec_tick shall be asserted in RUN only, on the carry out of tenths. o_day_tick shall be asserted together with the hours wrap.
REQ-030 An i_pulse level held high across multiple cycles shall produce exactly one increment.

Reset
REQ-031 While i_rst_n = 0, the outputs shall be:
- all digits 0;
- o_mode = RUN;
- o_sec_tick = 0 and o_day_tick = 0.
REQ-032 On reset, the edge-history registers shall be set to 1, so an input already high at reset release does not create an edge.
REQ-033 Reset asserted mid-count or mid-set shall take effect immediately, asynchronously. Operation shall resume at the first clock edge after deassertion.

Structure
REQ-034 Package clock_pkg shall hold:
- the mode enum: RUN, SET_HR, SET_MIN;
- BCD limit constants: 9 and 5;
- the tenths-per-second constant, 10.
REQ-035 Sub-module rise_edge_detect (clock, reset, input, edge out) shall be instantiated three times, once each for i_pulse, i_set and i_inc.

Verification
REQ-036 Reset release, then 10 i_pulse edges, each held high for 5 cycles -> o_sec_u = 1, o_tenth = 0, and exactly one o_sec_tick.
REQ-037 Preload 23:59:59.9 by set mode plus ticks, then one i_pulse edge -> 00:00:00.0 and an o_day_tick strobe.
REQ-038 In SET_HR at hour 23, one i_inc edge -> hour 00, minutes unchanged. In SET_MIN at 59, one i_inc edge -> 00, hours unchanged.
REQ-039 i_set and i_inc rising in the same cycle in SET_HR -> hour increments by 1, and o_mode becomes 2 in the next cycle.
REQ-040 i_run = 0 with 20 i_pulse edges -> no digit change. Then i_rst_n pulsed low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD time-of-day keeper.
// Holds the mode encoding, the digit limits and the mode-advance helper.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    localparam logic [3:0]  BCD_UNITS_MAX  = 4'd9;
    localparam logic [2:0]  BCD_TENS_MAX   = 3'd5;
    localparam int unsigned TENTHS_PER_SEC = 10;
    localparam logic [3:0]  TENTH_MAX      = 4'(TENTHS_PER_SEC - 1);

    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// One-register rising-edge detector; the history resets high so a level
// already asserted when reset releases is not seen as an edge.
module rise_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic hist_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= i_sig;
        end
    end

    assign o_edge = i_sig & ~hist_q;

endmodule

// File: rtl/clock_time_keeper.sv
// BCD time-of-day keeper driven by a 100 ms tick, with hour/minute set mode.
// Digits are kept directly in BCD registers that double as the outputs.
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter int unsigned P_HOUR_MAX = 23
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pulse,
    input  logic       i_run,
    input  logic       i_set,
    input  logic       i_inc,
    output logic [1:0] o_hr_t,
    output logic [3:0] o_hr_u,
    output logic [2:0] o_min_t,
    output logic [3:0] o_min_u,
    output logic [2:0] o_sec_t,
    output logic [3:0] o_sec_u,
    output logic [3:0] o_tenth,
    output logic [1:0] o_mode,
    output logic       o_sec_tick,
    output logic       o_day_tick
);

    localparam logic [1:0] HR_MAX_T = 2'(P_HOUR_MAX / 10);
    localparam logic [3:0] HR_MAX_U = 4'(P_HOUR_MAX % 10);

    logic  pulse_e;
    logic  set_e;
    logic  inc_e;
    mode_t mode_q;

    rise_edge_detect u_pulse_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_pulse),
        .o_edge  (pulse_e)
    );

    rise_edge_detect u_set_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_set),
        .o_edge  (set_e)
    );

    rise_edge_detect u_inc_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sig   (i_inc),
        .o_edge  (inc_e)
    );

    logic run_tick;
    logic c_tenth;
    logic c_sec_u;
    logic c_sec;
    logic min_step;
    logic c_min_u;
    logic c_min;
    logic hr_step;
    logic hr_wrap;
    logic day_wrap;

    // Minute and hour steppers are shared between the running carry chain
    // and the set-mode increment; the carry out of minutes only reaches
    // hours while running.
    always_comb begin
        run_tick = 1'b0;
        c_tenth  = 1'b0;
        c_sec_u  = 1'b0;
        c_sec    = 1'b0;
        min_step = 1'b0;
        c_min_u  = 1'b0;
        c_min    = 1'b0;
        hr_step  = 1'b0;
        hr_wrap  = 1'b0;
        day_wrap = 1'b0;

        run_tick = (mode_q == RUN) && i_run && pulse_e;
        c_tenth  = run_tick && (o_tenth == TENTH_MAX);
        c_sec_u  = c_tenth && (o_sec_u == BCD_UNITS_MAX);
        c_sec    = c_sec_u && (o_sec_t == BCD_TENS_MAX);
        min_step = c_sec || ((mode_q == SET_MIN) && inc_e);
        c_min_u  = min_step && (o_min_u == BCD_UNITS_MAX);
        c_min    = c_min_u && (o_min_t == BCD_TENS_MAX);
        hr_step  = ((mode_q == RUN) && c_min) || ((mode_q == SET_HR) && inc_e);
        hr_wrap  = (o_hr_t == HR_MAX_T) && (o_hr_u == HR_MAX_U);
        day_wrap = (mode_q == RUN) && c_min && hr_wrap;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q     <= RUN;
            o_hr_t     <= '0;
            o_hr_u     <= '0;
            o_min_t    <= '0;
            o_min_u    <= '0;
            o_sec_t    <= '0;
            o_sec_u    <= '0;
            o_tenth    <= '0;
            o_sec_tick <= 1'b0;
            o_day_tick <= 1'b0;
        end else begin
            if (mode_q != RUN) begin
                o_tenth <= '0;
                o_sec_t <= '0;
                o_sec_u <= '0;
            end else begin
                if (run_tick) begin
                    o_tenth <= c_tenth ? 4'd0 : o_tenth + 4'd1;
                end
                if (c_tenth) begin
                    o_sec_u <= c_sec_u ? 4'd0 : o_sec_u + 4'd1;
                end
                if (c_sec_u) begin
                    o_sec_t <= c_sec ? 3'd0 : o_sec_t + 3'd1;
                end
            end

            if (min_step) begin
                o_min_u <= c_min_u ? 4'd0 : o_min_u + 4'd1;
            end
            if (c_min_u) begin
                o_min_t <= c_min ? 3'd0 : o_min_t + 3'd1;
            end

            if (hr_step) begin
                if (hr_wrap) begin
                    o_hr_t <= '0;
                    o_hr_u <= '0;
                end else if (o_hr_u == BCD_UNITS_MAX) begin
                    o_hr_t <= o_hr_t + 2'd1;
                    o_hr_u <= '0;
                end else begin
                    o_hr_u <= o_hr_u + 4'd1;
                end
            end

            o_sec_tick <= c_tenth;
            o_day_tick <= day_wrap;

            // Increment above used the pre-advance mode; the mode moves last.
            if (set_e) begin
                mode_q <= next_mode(mode_q);
            end
        end
    end

    assign o_mode = mode_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed-vector bench for clock_time_keeper; inputs are driven and outputs
// sampled on the falling clock edge, tick strobes are counted by a monitor.
module tb_clock_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse, run, set, inc;
    logic [1:0] hr_t;
    logic [3:0] hr_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] tenth;
    logic [1:0] mode;
    logic       sec_tick, day_tick;

    int n_vec = 0;
    int n_bad = 0;
    int sec_ticks = 0;
    int day_ticks = 0;
    int base_sec;
    int base_day;

    clock_time_keeper #(.P_HOUR_MAX(23)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pulse    (pulse),
        .i_run      (run),
        .i_set      (set),
        .i_inc      (inc),
        .o_hr_t     (hr_t),
        .o_hr_u     (hr_u),
        .o_min_t    (min_t),
        .o_min_u    (min_u),
        .o_sec_t    (sec_t),
        .o_sec_u    (sec_u),
        .o_tenth    (tenth),
        .o_mode     (mode),
        .o_sec_tick (sec_tick),
        .o_day_tick (day_tick)
    );

    always #5 clk = ~clk;

    // Count strobes 2 ns after the active edge, well clear of both edges.
    always @(posedge clk) begin
        #2;
        if (sec_tick === 1'b1) sec_ticks++;
        if (day_tick === 1'b1) day_ticks++;
    end

    // Time packed one digit per nibble, so 23:59:59.9 reads as 28'h2359599.
    function automatic logic [27:0] tv();
        return {2'b00, hr_t, hr_u, 1'b0, min_t, min_u, 1'b0, sec_t, sec_u, tenth};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick_pulse(input int hold);
        pulse = 1'b1;
        repeat (hold) @(negedge clk);
        pulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_set();
        set = 1'b1;
        @(negedge clk);
        set = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc = 1'b1;
            @(negedge clk);
            inc = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pulse = 1'b1;
        run   = 1'b1;
        set   = 1'b0;
        inc   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_time", 32'(tv()), 32'h0000000);
        check_val("reset_mode", 32'(mode), 32'd0);
        check_val("reset_ticks", {30'd0, sec_tick, day_tick}, 32'd0);

        // Pulse already high at release must not count.
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("no_edge_at_release", 32'(tv()), 32'h0000000);
        pulse = 1'b0;
        @(negedge clk);

        // Ten tenths with a 5-cycle held level each.
        base_sec = sec_ticks;
        pulse = 1'b1;
        @(negedge clk);
        check_val("latency_one_cycle", 32'(tenth), 32'd1);
        repeat (4) @(negedge clk);
        pulse = 1'b0;
        @(negedge clk);
        check_val("held_level_once", 32'(tenth), 32'd1);
        for (int i = 0; i < 9; i++) tick_pulse(5);
        check_val("ten_tenths", 32'(tv()), 32'h0000010);
        check_val("one_sec_tick", 32'(sec_ticks - base_sec), 32'd1);

        // Preload 23:59 via set mode; seconds are cleared on entry.
        press_set();
        check_val("mode_set_hr", 32'(mode), 32'd1);
        check_val("set_clears_sec", 32'(tv()), 32'h0000000);
        tick_pulse(1);
        check_val("pulse_ignored_set", 32'(tv()), 32'h0000000);
        press_inc(23);
        check_val("hr_to_23", 32'(tv()), 32'h2300000);
        press_set();
        check_val("mode_set_min", 32'(mode), 32'd2);
        press_inc(59);
        check_val("min_to_59", 32'(tv()), 32'h2359000);
        press_set();
        check_val("mode_run", 32'(mode), 32'd0);
        for (int i = 0; i < 599; i++) tick_pulse(1);
        check_val("preload_full", 32'(tv()), 32'h2359599);

        // Day rollover.
        base_day = day_ticks;
        pulse = 1'b1;
        @(negedge clk);
        check_val("rollover_time", 32'(tv()), 32'h0000000);
        check_val("day_tick_high", 32'(day_tick), 32'd1);
        check_val("sec_tick_on_roll", 32'(sec_tick), 32'd1);
        pulse = 1'b0;
        @(negedge clk);
        check_val("day_tick_low", 32'(day_tick), 32'd0);
        check_val("one_day_tick", 32'(day_ticks - base_day), 32'd1);

        // Hour and minute wraps in set mode.
        press_set();
        press_inc(23);
        press_set();
        press_inc(59);
        press_set();
        check_val("pre_wrap", 32'(tv()), 32'h2359000);
        base_day = day_ticks;
        press_set();
        press_inc(1);
        check_val("hr_wrap_set", 32'(tv()), 32'h0059000);
        press_inc(5);
        press_set();
        press_inc(1);
        check_val("min_wrap_no_carry", 32'(tv()), 32'h0500000);
        check_val("no_day_tick_set", 32'(day_ticks - base_day), 32'd0);

        // Simultaneous set and inc in SET_HR.
        press_set();
        press_set();
        check_val("back_set_hr", 32'(mode), 32'd1);
        set = 1'b1;
        inc = 1'b1;
        @(negedge clk);
        check_val("simul_hr", 32'(tv()), 32'h0600000);
        check_val("simul_mode", 32'(mode), 32'd2);
        set = 1'b0;
        inc = 1'b0;
        @(negedge clk);
        press_set();
        press_inc(2);
        check_val("inc_ignored_run", 32'(tv()), 32'h0600000);

        // Frozen while i_run is low.
        run = 1'b0;
        base_sec = sec_ticks;
        for (int i = 0; i < 20; i++) tick_pulse(2);
        check_val("frozen", 32'(tv()), 32'h0600000);
        run = 1'b1;
        for (int i = 0; i < 13; i++) tick_pulse(1);
        check_val("resume_run", 32'(tv()), 32'h0600013);
        check_val("resume_sec_ticks", 32'(sec_ticks - base_sec), 32'd1);

        // Asynchronous reset while in SET_HR.
        press_set();
        check_val("mode_before_rst", 32'(mode), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_time", 32'(tv()), 32'h0000000);
        check_val("async_rst_mode", 32'(mode), 32'd0);
        check_val("async_rst_ticks", {30'd0, sec_tick, day_tick}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick_pulse(1);
        check_val("after_rst_count", 32'(tv()), 32'h0000001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
